// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, valid/ready byte output and frame status.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVS_FACTOR);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntMid  = CntW'(OVS_FACTOR / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVS_FACTOR - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   rx_meta_q, rx_s_q;
  logic                   frame_done;
  logic                   frame_par;

  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   pe_q, pe_d;
  logic                   ovr_q, ovr_d;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_calc_q, par_calc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_calc_q <= 1'b0;
    else       par_calc_q <= par_calc_d;
  end

  assign frame_par = par_calc_q;
`else
  assign frame_par = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_calc_d = par_calc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tick_16x && !rx_s_q) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick_16x) begin
          if (cnt_q == CntMid) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick_16x) begin
          // Wraps to zero on the sample tick since OVS_FACTOR is a power of two.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick_16x) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            par_calc_d = (^shift_q) ^ rx_s_q;
            state_d    = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick_16x) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            frame_done = 1'b1;
            state_d    = rx_s_q ? StIdle : StBreak;
          end
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output holding register; a frame finishing while the old byte is unread is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = 1'b0;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        fe_d    = !rx_s_q;
        pe_d    = frame_par;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != StIdle);

endmodule
